// File: rtl/pc_fetch_if_if.sv
// pc_fetch_if_if: sram-like instruction port between the fetch stage and memory.
interface pc_fetch_if_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );
    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: IF stage; holds the PC, fetches one instruction at a time and
// redirects on ID branches (delay-slot aware) and on exception flushes.
module pc_fetch_if #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          branch_jump,
    input  logic [31:0]   bj_address,
    input  logic          id_allow_in,
    input  logic          flush,
    input  logic [31:0]   flush_pc,
    pc_fetch_if_if.master bus,
    output logic          if_valid,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_inst
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DISCARD} state_t;
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, pend_tgt, pend_tgt_nx, issued_pc, issued_pc_nx;
    logic        pend, pend_nx;
    logic        taken, addr_acc, data_take;

    assign taken         = branch_jump & id_allow_in;
    assign addr_acc      = (state == S_REQ) & bus.inst_addr_ok;
    assign data_take     = (state == S_WAIT) & bus.inst_data_ok & ~flush;
    assign bus.inst_req  = resetn & (state == S_REQ);
    assign bus.inst_addr = pc;
    assign if_valid      = state == S_OUT;

    always_comb begin
        state_nx = state;
        case (state)
            S_REQ:     state_nx = bus.inst_addr_ok ? (flush ? S_DISCARD : S_WAIT) : S_REQ;
            S_WAIT:    state_nx = bus.inst_data_ok ? (flush ? S_REQ : S_OUT)
                                                   : (flush ? S_DISCARD : S_WAIT);
            S_OUT:     state_nx = (flush | id_allow_in) ? S_REQ : S_OUT;
            S_DISCARD: state_nx = bus.inst_data_ok ? S_REQ : S_DISCARD;
            default:   state_nx = S_REQ;
        endcase
    end

    // A taken branch before the delay slot is issued is parked in pend/pend_tgt.
    always_comb begin
        pc_nx        = pc;
        pend_nx      = pend;
        pend_tgt_nx  = pend_tgt;
        issued_pc_nx = addr_acc ? pc : issued_pc;
        if (flush) begin
            pc_nx   = flush_pc;
            pend_nx = 1'b0;
        end else if (addr_acc) begin
            pc_nx   = taken ? bj_address : pend ? pend_tgt : pc + 32'd4;
            pend_nx = 1'b0;
        end else if (taken && state == S_REQ) begin
            pend_nx     = 1'b1;
            pend_tgt_nx = bj_address;
        end else if (taken && (state == S_WAIT || state == S_OUT)) begin
            pc_nx = bj_address;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            pend      <= 1'b0;
            pend_tgt  <= 32'd0;
            issued_pc <= 32'd0;
            if_pc     <= 32'd0;
            if_inst   <= 32'd0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            pend      <= pend_nx;
            pend_tgt  <= pend_tgt_nx;
            issued_pc <= issued_pc_nx;
            if (data_take) begin
                if_pc   <= issued_pc;
                if_inst <= bus.inst_rdata;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_if.sv
// tb_pc_fetch_if: randomized bench; an instruction-stream model predicts the PCs
// handed to ID and a negedge monitor checks them plus the handshake timing rules.
module tb_pc_fetch_if;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        branch_jump = 1'b0, id_allow_in = 1'b0, flush = 1'b0;
    logic [31:0] bj_address = 32'd0, flush_pc = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    pc_fetch_if_if bus();

    pc_fetch_if #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .resetn(resetn),
        .branch_jump(branch_jump),
        .bj_address(bj_address),
        .id_allow_in(id_allow_in),
        .flush(flush),
        .flush_pc(flush_pc),
        .bus(bus),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [31:0] exp_q[$];

    // memory model and instruction-stream model state
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'd0, acc_addr = 32'd0;
    logic [31:0] next_pc = RESET_PC, redir_tgt = 32'd0;
    logic        redir = 1'b0, id_has = 1'b0, id_ds = 1'b0;
    logic        zero_wait = 1'b0;
    int          p_aok = 0, p_dok = 0, p_allow = 0, p_br = 0, p_fl = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        next_pc  = RESET_PC;
        redir    = 1'b0;
        id_has   = 1'b0;
        id_ds    = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        resetn           = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'd0;
        branch_jump      = 1'b0;
        id_allow_in      = 1'b0;
        flush            = 1'b0;
        reset_model();
        repeat (n) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic knobs(input int a, input int d, input int al, input int b, input int f);
        p_aok = a; p_dok = d; p_allow = al; p_br = b; p_fl = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.inst_data_ok) mem_busy = 1'b0;
        if (bus.inst_addr_ok) begin
            mem_busy = 1'b1;
            mem_addr = acc_addr;
        end
        bus.inst_addr_ok = bus.inst_req && !mem_busy && (zero_wait || $urandom_range(99) < p_aok);
        if (bus.inst_addr_ok) acc_addr = bus.inst_addr;
        bus.inst_data_ok = mem_busy && (zero_wait || $urandom_range(99) < p_dok);
        bus.inst_rdata   = bus.inst_data_ok ? word(mem_addr) : $urandom;
        id_allow_in = $urandom_range(99) < p_allow;
        branch_jump = id_allow_in ? (id_has && !id_ds && $urandom_range(99) < p_br)
                                  : ($urandom_range(99) < 10);
        bj_address  = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8
                                               : (($urandom & 32'h0000_0FFC) | 32'h0040_0000);
        flush       = $urandom_range(99) < p_fl;
        case ($urandom_range(2))
            0:       flush_pc = 32'hBFC0_0380;
            1:       flush_pc = 32'hFFFF_FFFC;
            default: flush_pc = $urandom & 32'h0000_FFFC;
        endcase
        // expected stream: sequential, except the instruction after a delay slot is the target
        if (flush) begin
            exp_q.delete();
            next_pc = flush_pc;
            redir   = 1'b0;
            id_has  = 1'b0;
        end else begin
            if (branch_jump && id_allow_in) begin
                redir     = 1'b1;
                redir_tgt = bj_address;
            end
            if (id_allow_in) id_has = 1'b0;
            if (id_allow_in && if_valid) begin
                exp_q.push_back(next_pc);
                id_has  = 1'b1;
                id_ds   = redir;
                next_pc = redir ? redir_tgt : next_pc + 32'd4;
                redir   = 1'b0;
            end
        end
    endtask

    // monitor state
    int          n_cyc = 0, last_addr = -100, last_data = -100, idle_cnt = 0;
    logic        prev_resetn = 1'b0, prev_hold = 1'b0, prev_pend = 1'b0, prev_valid = 1'b0;
    logic [31:0] hold_pc = 32'd0, hold_inst = 32'd0, pend_addr = 32'd0, e = 32'd0;

    always @(negedge clk) begin
        n_cyc++;
        if (!resetn) begin
            chk("req_low_in_reset", 96'(bus.inst_req), 96'd0);
            if (!prev_resetn) chk("reset_regs", 96'({if_valid, if_pc, if_inst}), 96'd0);
            prev_hold  = 1'b0;
            prev_pend  = 1'b0;
            prev_valid = 1'b0;
            idle_cnt   = 0;
        end else begin
            if (!prev_resetn)
                chk("first_req", 96'({bus.inst_req, bus.inst_addr}), 96'({1'b1, RESET_PC}));
            if (prev_hold)
                chk("stall_hold", 96'({if_valid, bus.inst_req, if_pc, if_inst}),
                    96'({2'b10, hold_pc, hold_inst}));
            if (prev_pend)
                chk("addr_stable", 96'({bus.inst_req, bus.inst_addr}), 96'({1'b1, pend_addr}));
            if (bus.inst_req) chk("single_outstanding", 96'(mem_busy), 96'd0);
            if (if_valid && !prev_valid) begin
                chk("valid_after_data_ok", 96'(n_cyc - last_data), 96'd1);
                chk("addr_to_valid_min2", 96'((n_cyc - last_addr) >= 2), 96'd1);
                if (zero_wait) chk("zero_wait_latency", 96'(n_cyc - last_addr), 96'd2);
            end
            idle_cnt++;
            if (if_valid && id_allow_in && !flush) begin
                idle_cnt = 0;
                chk("scoreboard_depth", 96'(exp_q.size()), 96'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("delivered_pc_inst", 96'({if_pc, if_inst}), 96'({e, word(e)}));
                end
            end
            if (idle_cnt > 400) begin
                chk("progress_timeout", 96'(idle_cnt), 96'd0);
                idle_cnt = 0;
            end
            if (bus.inst_req && bus.inst_addr_ok) last_addr = n_cyc;
            if (bus.inst_data_ok) last_data = n_cyc;
            prev_hold  = if_valid && !id_allow_in && !flush;
            hold_pc    = if_pc;
            hold_inst  = if_inst;
            prev_pend  = bus.inst_req && !bus.inst_addr_ok && !flush;
            pend_addr  = bus.inst_addr;
            prev_valid = if_valid;
        end
        prev_resetn = resetn;
    end

    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'd0;
        apply_reset(3);
        zero_wait = 1'b1;
        knobs(100, 100, 100, 0, 0);
        repeat (15) step();
        zero_wait = 1'b0;
        knobs(50, 50, 70, 30, 3);
        repeat (3000) step();
        knobs(80, 30, 20, 40, 2);
        repeat (2000) step();
        knobs(30, 70, 90, 50, 8);
        repeat (2000) step();
        apply_reset(2);
        knobs(60, 60, 60, 35, 5);
        repeat (3000) step();
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_fetch_if.md
# pc_fetch_if

Instruction-fetch (IF) stage of the CPU pipeline. It holds the PC, issues one instruction request at a time on the sram-like instruction port, and registers the returned word for ID. It is redirected by the ID-stage branch/jump resolver (`branch_jump`/`bj_address`) with MIPS delay-slot semantics, and by the exception unit (`flush`/`flush_pc`).

## Interface
- `RESET_PC`, 32'hBFC0_0000, PC value loaded at reset.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `branch_jump`  in  1  ID resolved a taken branch/jump. Sampled only when `id_allow_in`=1.
- `bj_address`  in  32  target address; valid with `branch_jump`.
- `id_allow_in`  in  1  ID accepts a new instruction this cycle, and the ID instruction moves to EX.
- `flush`  in  1  exception/eret redirect; highest priority.
- `flush_pc`  in  32  redirect address for `flush`.
- `inst_req`  out  1  request valid.
- `inst_addr`  out  32  request address; equals `pc`.
- `inst_addr_ok`  in  1  address accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  32  read data.
- `if_valid`  out  1  `if_pc`/`if_inst` hold a valid instruction for ID.
- `if_pc`  out  32  PC of the held instruction.
- `if_inst`  out  32  held instruction word.

## Operation
- Registers: `pc[31:0]`, `pend`, `pend_tgt[31:0]`, state, and the `if_pc`/`if_inst` output registers.
- State machine:
  - S_REQ: `inst_req`=1. On `inst_addr_ok` -> S_WAIT.
  - S_WAIT: on `inst_data_ok`, load `if_inst`<=`inst_rdata` and `if_pc`<=issued address -> S_OUT.
  - S_OUT: `if_valid`=1. On `id_allow_in` -> S_REQ.
  - S_DISCARD: wait for `inst_data_ok`, drop the data -> S_REQ.
- Only one request is outstanding at a time. `inst_req` is asserted only in S_REQ.
- PC update on address acceptance: `pc`<=`pend ? pend_tgt : pc+4`, and `pend`<=0.
- Redirect capture uses `taken = branch_jump & id_allow_in`. The delay slot is the instruction at branch PC+4, currently owned by IF.
  - In S_REQ without `inst_addr_ok`, the delay slot is not yet issued: `pend`<=1, `pend_tgt`<=`bj_address`.
  - In S_REQ with `inst_addr_ok` the same cycle, or in S_WAIT/S_OUT, the delay slot is already issued: `pc`<=`bj_address` directly.
- Flush overrides every other update: `pc`<=`flush_pc`, `pend`<=0, `if_valid`<=0.
  - From S_REQ without addr_ok -> S_REQ.
  - From S_REQ with addr_ok -> S_DISCARD.
  - From S_WAIT without data_ok -> S_DISCARD.
  - From S_WAIT with data_ok -> S_REQ, data dropped.
  - From S_OUT -> S_REQ.
  - From S_DISCARD -> stays in S_DISCARD until data_ok.
- `inst_addr` changes during a pending (unaccepted) S_REQ only on `flush` or reset.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. Address bits [1:0] are not checked here.

## Timing
- Reset (`resetn`=0 at a clk edge): `pc`=`RESET_PC`, state=S_REQ, `pend`=0, `pend_tgt`=0, `if_valid`=0, `if_pc`=0, `if_inst`=0. While `resetn`=0, `inst_req` is forced to 0.
- Reset mid-transaction: any in-flight data is ignored. A data_ok arriving after reset is not expected; the bus is reset together with the CPU.
- `inst_req` rises in the first cycle after `resetn` goes high.
- Latency: from `inst_addr_ok` to `if_valid` is ≥2 cycles; `if_valid` rises the cycle after `inst_data_ok`. `inst_data_ok` never coincides with `inst_addr_ok` for the same request.
- With zero-wait memory, one instruction completes every 3 cycles (REQ, WAIT, OUT).
- S_OUT holds `if_pc`/`if_inst` stable while `id_allow_in`=0.
- `branch_jump` with `id_allow_in`=0 is ignored; ID re-presents it.
- `taken` and `flush` in the same cycle: flush wins and `pend` is cleared.

## Test plan
- Reset sequencing: hold `resetn`=0 for 3 cycles, then release with zero-wait memory -> `inst_req`=0 during reset, and addresses BFC00000, BFC00004, BFC00008 are issued in order. `if_valid` rises 2 cycles after each addr_ok.
- Branch with pending delay slot: branch at 0x100 in ID, IF in S_REQ at 0x104 with addr_ok held low, `taken` with target 0x200 -> `pend`=1. Next issued addresses are 0x104, then 0x200.
- Branch with delay slot already issued: `taken` while in S_WAIT for 0x104 (pc=0x108), target 0x200 -> 0x108 is never issued and the next address is 0x200. Repeat with `taken` coinciding with addr_ok of 0x104: same result.
- Flush during wait: flush to 0xBFC00380 while in S_WAIT, data_ok 2 cycles later with 0xDEADBEEF -> data dropped, `if_valid` stays 0, and the next address is 0xBFC00380. Also cover flush together with `taken`: `pend` is cleared and the target is never fetched.
- Stall hold: S_OUT with `if_pc`=0x300 and `id_allow_in`=0 for 4 cycles -> `if_valid`/`if_pc`/`if_inst` stable and `inst_req`=0. Next request 0x304 appears the cycle after `id_allow_in`=1.
- Wrap-around: `flush_pc`=0xFFFFFFFC -> addresses 0xFFFFFFFC then 0x00000000 are issued.
